// File: rtl/core_pkg.sv
// core_pkg: shared encodings and state type for the MEM stage
package core_pkg;
  localparam logic [1:0] DSIZE_B = 2'b00;
  localparam logic [1:0] DSIZE_H = 2'b01;
  localparam logic [1:0] DSIZE_W = 2'b10;
  localparam int MEMRW_LD = 1;
  localparam int MEMRW_ST = 0;
  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane shift/byte-enables and load extract/extend
// Ports: lane (addr[1:0]), dsize, zext | sdata -> wdata, be | rdata -> ldata
module mem_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  dsize,
  input  logic        zext,
  input  logic [31:0] sdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);
  logic [31:0] r;
  always_comb begin
    wdata = dsize == DSIZE_B ? sdata << {lane, 3'b000} : dsize == DSIZE_H ? sdata << {lane[1], 4'b0000} : sdata;
    be = dsize == DSIZE_B ? 4'b0001 << lane : dsize == DSIZE_H ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    r = dsize == DSIZE_B ? rdata >> {lane, 3'b000} : dsize == DSIZE_H ? rdata >> {lane[1], 4'b0000} : rdata;
    ldata = dsize == DSIZE_B ? {{24{~zext & r[7]}}, r[7:0]} : dsize == DSIZE_H ? {{16{~zext & r[15]}}, r[15:0]} : r;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage, handshaked data-memory access feeding MEM/WB
// Ports: EX/MEM inputs (*_pype/_pype2), mem_keep stall, dmem_* request/response,
// MEM/WB outputs (*_pype3), mem_fault (timeout), mem_misalign.
// Optional: MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses without a request.
module mem_access
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_co_pype,
  input  logic [31:0] read_data2_pype2,
  input  logic [31:0] PCp4_pype2,
  input  logic [4:0]  WReg_pype2,
  input  logic [2:0]  writeback_control_pype2,
  input  logic [1:0]  MemRW_pype2,
  input  logic [1:0]  dsize_pype2,
  input  logic [2:0]  funct3_pype2,
  output logic        mem_keep,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ALU_co_pype3,
  output logic [31:0] read_data_pype3,
  output logic [31:0] PCp4_pype3,
  output logic [4:0]  WReg_pype3,
  output logic [2:0]  writeback_control_pype3,
  output logic        mem_fault,
  output logic        mem_misalign
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  mem_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] rdata_q, wdata, ldata;
  logic [3:0] be;
  logic fault_q, mis_q, mis, is_mem, is_ld, timeout, done;
  assign is_mem = |MemRW_pype2;
  // 11 is treated as a store, so only a pure 10 returns load data
  assign is_ld = MemRW_pype2[MEMRW_LD] & ~MemRW_pype2[MEMRW_ST];
  assign cnt_n = cnt + CW'(1);
  assign timeout = cnt_n == CW'(TIMEOUT_CYCLES);
  assign done = state == DONE;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (dsize_pype2 == DSIZE_H && ALU_co_pype[0]) || (dsize_pype2 == DSIZE_W && |ALU_co_pype[1:0]);
`else
  assign mis = 1'b0;
`endif
  mem_lane_align u_align (
    .lane  (ALU_co_pype[1:0]),
    .dsize (dsize_pype2),
    .zext  (funct3_pype2[2]),
    .sdata (read_data2_pype2),
    .wdata (wdata),
    .be    (be),
    .rdata (rdata_q),
    .ldata (ldata)
  );
  always_comb begin
    state_n = state;
    mem_keep = 1'b0;
    unique case (state)
      IDLE: begin
        mem_keep = is_mem;
        state_n = !is_mem ? IDLE : mis ? DONE : REQ;
      end
      REQ: begin
        mem_keep = 1'b1;
        state_n = (dmem_ack || timeout) ? DONE : REQ;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      mis_q <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_be <= '0;
      ALU_co_pype3 <= '0;
      read_data_pype3 <= '0;
      PCp4_pype3 <= '0;
      WReg_pype3 <= '0;
      writeback_control_pype3 <= '0;
      mem_fault <= 1'b0;
      mem_misalign <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && is_mem) begin
        cnt <= '0;
        rdata_q <= '0;
        fault_q <= 1'b0;
        mis_q <= mis;
        dmem_req <= ~mis;
        if (!mis) begin
          dmem_we <= MemRW_pype2[MEMRW_ST];
          dmem_addr <= {ALU_co_pype[31:2], 2'b00};
          dmem_wdata <= wdata;
          dmem_be <= be;
        end
      end
      if (state == REQ) begin
        if (dmem_ack) begin
          dmem_req <= 1'b0;
          rdata_q <= dmem_rdata;
        end else if (timeout) begin
          dmem_req <= 1'b0;
          fault_q <= 1'b1;
        end else begin
          cnt <= cnt_n;
        end
      end
      // MEM/WB advances whenever the stage is not stalling; flags only matter on completion
      if (!mem_keep) begin
        ALU_co_pype3 <= ALU_co_pype;
        read_data_pype3 <= (done && is_ld && !mis_q) ? ldata : 32'h0;
        PCp4_pype3 <= PCp4_pype2;
        WReg_pype3 <= WReg_pype2;
        writeback_control_pype3 <= (done && (fault_q || mis_q)) ? 3'b000 : writeback_control_pype2;
        mem_fault <= done & fault_q;
        mem_misalign <= done & mis_q;
      end
    end
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access (MEM) stage of the 5-stage RV32I pipeline; consumes the EX/MEM pipeline register produced by the execute stage and is the responder to its memory requests. Turns address, store data, size and read/write controls into a handshaked data-memory transaction, with byte-lane alignment on stores and sign/zero extension on loads. Stalls upstream through `mem_keep` while a transaction is outstanding, then loads the MEM/WB pipeline register.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: REQ-state cycles without `dmem_ack` before the access is aborted; counter width `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ALU_co_pype` in 32: effective address, or ALU result for non-memory ops.
- `read_data2_pype2` in 32: store data, already zero-masked to size in bits [7:0], [15:0] or [31:0].
- `PCp4_pype2` in 32, `WReg_pype2` in 5, `writeback_control_pype2` in 3: pass-through to WB.
- `MemRW_pype2` in 2: [1] load, [0] store; 00 means no access. 11 is illegal and treated as store.
- `dsize_pype2` in 2: 00 byte, 01 half, 10 word.
- `funct3_pype2` in 3: bit 2 set selects zero extension (LBU/LHU).
- `mem_keep` out 1: hold EX/MEM and all earlier stages; combinational from state and inputs.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (`{addr[31:2],2'b00}`), `dmem_wdata` out 32, `dmem_be` out 4: request channel, all registered.
- `dmem_ack` in 1, `dmem_rdata` in 32: response; rdata is valid in the ack cycle.
- `ALU_co_pype3` out 32, `read_data_pype3` out 32, `PCp4_pype3` out 32, `WReg_pype3` out 5, `writeback_control_pype3` out 3: MEM/WB register.
- `mem_fault` out 1: timeout abort, registered with MEM/WB.
- `mem_misalign` out 1: misaligned access, registered with MEM/WB (see Configuration).

## Operation
- FSM has three states: IDLE, REQ, DONE.
- IDLE, `MemRW_pype2`==00:
  - pass-through op; `mem_keep`=0.
  - MEM/WB loads from the inputs; `read_data_pype3`=0.
- IDLE, `MemRW_pype2`!=00:
  - `mem_keep`=1; next state is REQ.
  - Registers `dmem_req`=1, `dmem_we`=`MemRW_pype2[0]`, address, `dmem_wdata` and `dmem_be`.
  - Clears the timeout counter.
- REQ:
  - `mem_keep`=1; `dmem_req` is held and the request fields are held stable.
  - On `dmem_ack`: capture `dmem_rdata`, drop `dmem_req` on the next edge, go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES`: drop `dmem_req`, set the fault flag, captured data = 0, go to DONE.
- DONE:
  - `mem_keep`=0.
  - MEM/WB loads the inputs, extended load data and the flags; next state is IDLE.
  - A fault forces `writeback_control_pype3`=0.
- Store lanes, with s = `ALU_co_pype[1:0]`:
  - byte: wdata = data<<8s, be = 0001<<s.
  - half: wdata = data<<16·s[1], be = 0011<<2·s[1].
  - word: wdata = data, be = 1111.
- Load extract:
  - byte: r = rdata>>8s, take r[7:0].
  - half: r = rdata>>16·s[1], take r[15:0].
  - word: rdata unchanged.
  - Then sign-extend, or zero-extend when `funct3_pype2[2]`=1.
- A late `dmem_ack` arriving outside REQ is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. In the cycle after `rst` is seen high, `dmem_req`=0, including when reset arrives mid-REQ.
- Non-memory op: one cycle in the stage, MEM/WB written at the end of that cycle.
- Memory op with ack in the first REQ cycle:
  - op arrives cycle N; REQ in N+1; DONE in N+2.
  - MEM/WB written at the end of N+2; `mem_keep` high in N and N+1.
- Each extra wait cycle adds one cycle.
- Back-to-back memory ops: the second is seen in IDLE at N+3; there is no bubble beyond the handshake.
- `dmem_req` never deasserts before ack or timeout; request fields never change while `dmem_req`=1.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned half (s[0]=1) or word (s!=0) detected in IDLE.
  - No request is issued; goes IDLE→DONE directly (`mem_keep`=1 for one cycle).
  - `mem_misalign`=1 with the op in MEM/WB; `writeback_control_pype3`=0.
- Undefined: the low address bits beyond lane selection are ignored, and `mem_misalign` is tied 0.

## Structure
- Shared package `core_pkg`:
  - dsize encodings (DSIZE_B/H/W), MemRW bit positions.
  - `mem_state_t` enum {IDLE, REQ, DONE}.
- Sub-module `mem_lane_align`: combinational store shift/byte-enable and load extract/extend. It is reused by any future store-buffer.
- FSM, timeout counter and the MEM/WB register stay in `mem_access`.

## Test plan
- ADD result 0x1234 and no access (MemRW=00) → `ALU_co_pype3`=0x1234 next edge, `mem_keep` never high, `dmem_req` stays 0.
- SB data 0xAB, addr 0x1003, ack after 2 wait cycles → `dmem_addr`=0x1000, be=1000, wdata=0xAB000000 stable for 3 cycles; `mem_keep` high for 4 cycles.
- LB vs LBU, addr 0x2001, rdata 0x0000_8000, immediate ack → `read_data_pype3` = 0xFFFFFF80 for LB, 0x00000080 for LBU; MEM/WB written 2 cycles after entry.
- LW with no ack, `TIMEOUT_CYCLES`=4 → `dmem_req` drops after 4 REQ cycles; `mem_fault`=1, `writeback_control_pype3`=0, data 0.
- `rst` asserted during REQ of SW 0xDEADBEEF → next cycle `dmem_req`=0 and all outputs 0; a late ack is ignored.
- With `MEM_MISALIGN_TRAP_EN`, LH at 0x3001 → no `dmem_req`, `mem_misalign`=1, `writeback_control_pype3`=0. Without the macro, the same access returns the lower halfword of word 0x3000 with `mem_misalign`=0.
